uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated write FIFO. It serialises DATA_BITS-wide words LSB-first onto `tx`, with an optional parity bit and 1 or 2 stop bits. Frames are paced by an external one-cycle baud tick. Software or an upstream block can queue up to FIFO_DEPTH words, and queued words go out back-to-back with no idle gap between frames. It sits between the bus-side register block and the pad, and is the configurable successor to the fixed 8N1/8E1 transmitter.

---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated write FIFO: DATA_BITS sent LSB-first, optional
// parity, 1 or 2 stop bits, paced by an external baud tick; queued words go out gapless.
module uart_tx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 full,
  output logic                 overflow,
  output logic [CW-1:0]        fifo_count,
  output logic                 busy,
  output logic                 tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_EN < 0 || PARITY_EN > 1 ||
      PARITY_TYPE < 0 || PARITY_TYPE > 1 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d, idx_inc;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 full_q, ovf_q;
  logic                 push, pop, parity_bit;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  assign push       = wr_en && !full_q;
  assign idx_inc    = idx_q + 1'b1;
  assign parity_bit = (^sh_q) ^ (PARITY_TYPE == 1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (cnt_q != '0) begin
            pop     = 1'b1;
            sh_d    = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = START;
          end
        end
        START: begin
          tx_d    = sh_q[0];
          idx_d   = '0;
          state_d = DATA;
        end
        DATA: begin
          if (idx_q < IDX_LAST) begin
            tx_d  = sh_q[idx_inc];
            idx_d = idx_inc;
          end else if (PARITY_EN == 1) begin
            tx_d    = parity_bit;
            state_d = PARITY;
          end else begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = STOP;
          end
        end
        PARITY: begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = STOP;
        end
        STOP: begin
          if (TWO_STOP && !stop_q) begin
            stop_d = 1'b1;
          end else if (cnt_q != '0) begin
            // Next word starts directly after the last stop bit, keeping frames gapless.
            pop     = 1'b1;
            sh_d    = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      sh_q     <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CW'(FIFO_DEPTH));
      ovf_q  <= wr_en && full_q;
    end
  end

  // NOTE: storage array has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign full       = full_q;
  assign overflow   = ovf_q;
  assign fifo_count = cnt_q;
  assign busy       = busy_q;
  assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor decodes frames into a scoreboard
// that is matched against words queued when stimulus is driven.
module tb_uart_tx_fifo;

  typedef struct { logic [7:0] data; logic par; } exp_t;
  typedef struct { logic [7:0] data; logic par; bit stop_ok; bit busy_ok; int gap; } got_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gen_tick = 1'b0, man_tick = 1'b0, tick_en = 1'b0;
  logic baud_tick;
  int   tick_period = 16;
  int   tick_cnt = 0;

  logic       wr_en = 1'b0, full, overflow, busy, tx;
  logic [7:0] data_in = '0;
  logic [2:0] fifo_count;
  logic       wr_b = 1'b0, full_b, ovf_b, busy_b, tx_b;
  logic [6:0] data_b = '0;
  logic [2:0] cnt_b;
  logic       wr_c = 1'b0, full_c, ovf_c, busy_c, tx_c;
  logic [7:0] data_c = '0;
  logic [2:0] cnt_c;

  int vectors = 0, miscompares = 0, glitches = 0, timeouts = 0;

  exp_t        exp_q[$];
  got_t        got_q[$];
  logic [15:0] bits_q[$];
  int          len_q[$];

  assign baud_tick = gen_tick | man_tick;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_en), .data_in(data_in),
    .full(full), .overflow(overflow), .fifo_count(fifo_count), .busy(busy), .tx(tx)
  );

  uart_tx_fifo #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_TYPE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_b), .data_in(data_b),
    .full(full_b), .overflow(ovf_b), .fifo_count(cnt_b), .busy(busy_b), .tx(tx_b)
  );

  uart_tx_fifo #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_TYPE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .wr_en(wr_c), .data_in(data_c),
    .full(full_c), .overflow(ovf_c), .fifo_count(cnt_c), .busy(busy_c), .tx(tx_c)
  );

  always @(posedge clk) begin
    #1;
    if (!tick_en) begin
      tick_cnt = 0;
      gen_tick = 1'b0;
    end else begin
      gen_tick = (tick_cnt == tick_period - 1);
      tick_cnt = gen_tick ? 0 : tick_cnt + 1;
    end
  end

  // What the DUT saw at the edge just taken, for the monitor sampling at the following negedge.
  logic tick_q = 1'b0, rst_q = 1'b1;
  always @(posedge clk) begin
    tick_q = baud_tick;
    rst_q  = rst;
  end

  logic tx_prev = 1'b1;
  bit   m_in = 1'b0;
  int   m_n = 0, m_gap = 0;
  got_t m_fr;

  always @(negedge clk) begin
    if (rst_q) begin
      m_in = 1'b0; m_n = 0; m_gap = 0; tx_prev = 1'b1;
    end else begin
      if (tx !== tx_prev && !tick_q) glitches++;
      tx_prev = tx;
      if (tick_q) begin
        if (!m_in) begin
          if (tx === 1'b0) begin
            m_in = 1'b1; m_n = 0;
            m_fr.data = '0; m_fr.par = 1'b0; m_fr.stop_ok = 1'b1;
            m_fr.busy_ok = (busy === 1'b1); m_fr.gap = m_gap; m_gap = 0;
          end else begin
            m_gap++;
          end
        end else begin
          if (busy !== 1'b1) m_fr.busy_ok = 1'b0;
          if (m_n < 8) m_fr.data[m_n] = tx;
          else if (m_n == 8) m_fr.par = tx;
          else if (tx !== 1'b1) m_fr.stop_ok = 1'b0;
          m_n++;
          if (m_n == 10) begin
            got_q.push_back(m_fr);
            m_in = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic even_par(input logic [7:0] d);
    logic p = 1'b0;
    for (int i = 0; i < 8; i++) p = p ^ d[i];
    return p;
  endfunction

  function automatic logic [15:0] model_frame(input logic [8:0] d, input int db, input int pe,
                                              input int pt, input int sb, output int len);
    logic [15:0] bits;
    logic p;
    bits = '1;
    bits[0] = 1'b0;
    p = (pt == 1);
    for (int i = 0; i < db; i++) begin
      bits[1+i] = d[i];
      p = p ^ d[i];
    end
    len = 1 + db;
    if (pe == 1) begin
      bits[len] = p;
      len++;
    end
    len = len + sb;
    return bits;
  endfunction

  task automatic expect_word(input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.par  = even_par(d);
    exp_q.push_back(e);
  endtask

  task automatic wait_tick();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!tick_q && guard < 100);
    if (!tick_q) timeouts++;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (busy !== 1'b0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (busy !== 1'b0) timeouts++;
  endtask

  task automatic collect(input int sel, input int len, output logic [15:0] bits);
    logic b = 1'b1;
    int guard = 0;
    bits = '1;
    while (b !== 1'b0 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (tick_q) b = (sel == 1) ? tx_b : tx_c;
    end
    if (b !== 1'b0) timeouts++;
    bits[0] = b;
    for (int i = 1; i < len; i++) begin
      wait_tick();
      bits[i] = (sel == 1) ? tx_b : tx_c;
    end
  endtask

  task automatic score_frames(input int n, input bit gapless, input string tag);
    int guard = 0;
    got_t g;
    exp_t e;
    while (got_q.size() < n && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (got_q.size() < n) begin
      vectors++; miscompares++;
      $display("FAIL %s frame_timeout: got %0d frames, need %0d", tag, got_q.size(), n);
    end
    for (int i = 0; i < n && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s unexpected_frame: data %02h, none queued", tag, g.data);
      end else begin
        e = exp_q.pop_front();
        if (g.data !== e.data) begin
          miscompares++; $display("FAIL %s data[%0d]: got %02h, expected %02h", tag, i, g.data, e.data);
        end
        vectors++;
        if (g.par !== e.par) begin
          miscompares++; $display("FAIL %s parity[%0d]: got %b, expected %b", tag, i, g.par, e.par);
        end
        vectors++;
        if (g.stop_ok !== 1'b1) begin
          miscompares++; $display("FAIL %s stop[%0d]: stop bit low, expected 1", tag, i);
        end
        vectors++;
        if (g.busy_ok !== 1'b1) begin
          miscompares++; $display("FAIL %s busy[%0d]: busy dropped mid-frame, expected 1", tag, i);
        end
        if (gapless && i > 0) begin
          vectors++;
          if (g.gap !== 0) begin
            miscompares++; $display("FAIL %s gap[%0d]: got %0d idle bits, expected 0", tag, i, g.gap);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b, expected 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b, expected 0", full); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b, expected 0", overflow); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d, expected 0", fifo_count); end
    vectors++; if (tx_b !== 1'b1) begin miscompares++; $display("FAIL reset_tx_b: got %b, expected 1", tx_b); end
    vectors++; if (tx_c !== 1'b1) begin miscompares++; $display("FAIL reset_tx_c: got %b, expected 1", tx_c); end
  endtask

  task automatic test_8e1();
    tick_period = 16;
    tick_en = 1'b1;
    @(posedge clk); #1 wr_en = 1'b1; data_in = 8'hA5; expect_word(8'hA5);
    @(posedge clk); #1 wr_en = 1'b0;
    score_frames(1, 1'b0, "8e1");
    wait_tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL 8e1_busy_end: got %b, expected 0", busy); end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL 8e1_tx_end: got %b, expected 1", tx); end
  endtask

  task automatic test_parity();
    logic [15:0] got_bits, exp_bits;
    int len;
    wait_idle();
    @(posedge clk); #1 wr_en = 1'b1; data_in = 8'h01; wr_c = 1'b1; data_c = 8'h01;
    expect_word(8'h01);
    bits_q.push_back(model_frame(9'h001, 8, 1, 1, 1, len));
    len_q.push_back(len);
    @(posedge clk); #1 wr_en = 1'b0; wr_c = 1'b0;
    len = len_q.pop_front();
    exp_bits = bits_q.pop_front();
    collect(2, len, got_bits);
    vectors++; if (got_bits !== exp_bits) begin miscompares++; $display("FAIL odd_frame: got %016b, expected %016b", got_bits, exp_bits); end
    vectors++; if (got_bits[9] !== 1'b0) begin miscompares++; $display("FAIL odd_parity_bit: got %b, expected 0", got_bits[9]); end
    score_frames(1, 1'b0, "even_par");
    wait_tick();
    vectors++; if (busy_c !== 1'b0) begin miscompares++; $display("FAIL odd_busy_end: got %b, expected 0", busy_c); end
  endtask

  task automatic test_7n2();
    logic [15:0] got_bits, exp_bits;
    int len;
    @(posedge clk); #1 wr_b = 1'b1; data_b = 7'h7F;
    bits_q.push_back(model_frame(9'h07F, 7, 0, 0, 2, len));
    len_q.push_back(len);
    @(posedge clk); #1 wr_b = 1'b0;
    len = len_q.pop_front();
    exp_bits = bits_q.pop_front();
    collect(1, len, got_bits);
    vectors++; if (got_bits !== exp_bits) begin miscompares++; $display("FAIL 7n2_frame: got %016b, expected %016b", got_bits, exp_bits); end
    wait_tick();
    vectors++; if (busy_b !== 1'b0) begin miscompares++; $display("FAIL 7n2_len_busy: got %b, expected 0", busy_b); end
    vectors++; if (tx_b !== 1'b1) begin miscompares++; $display("FAIL 7n2_len_tx: got %b, expected 1", tx_b); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3] = '{8'h11, 8'h22, 8'h33};
    wait_idle();
    tick_en = 1'b0;
    @(posedge clk); #1 wr_en = 1'b1; data_in = w[0];
    for (int i = 0; i < 3; i++) begin
      expect_word(w[i]);
      @(posedge clk); #1;
      if (i < 2) data_in = w[i+1];
      else wr_en = 1'b0;
      @(negedge clk);
      vectors++;
      if (fifo_count !== 3'(i + 1)) begin
        miscompares++; $display("FAIL b2b_count[%0d]: got %0d, expected %0d", i, fifo_count, i + 1);
      end
    end
    tick_en = 1'b1;
    score_frames(3, 1'b1, "b2b");
    wait_tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end: got %b, expected 0", busy); end
  endtask

  task automatic test_overflow();
    logic [7:0] w [5] = '{8'h80, 8'h41, 8'h3C, 8'hFE, 8'h99};
    wait_idle();
    tick_en = 1'b0;
    @(posedge clk); #1 wr_en = 1'b1; data_in = w[0];
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_word(w[i]);
      @(posedge clk); #1;
      if (i < 4) data_in = w[i+1];
      else wr_en = 1'b0;
      @(negedge clk);
      vectors++;
      if (fifo_count !== 3'((i < 4) ? i + 1 : 4)) begin
        miscompares++; $display("FAIL ovf_count[%0d]: got %0d, expected %0d", i, fifo_count, (i < 4) ? i + 1 : 4);
      end
      vectors++;
      if (full !== (i >= 3)) begin
        miscompares++; $display("FAIL ovf_full[%0d]: got %b, expected %b", i, full, i >= 3);
      end
      vectors++;
      if (overflow !== (i == 4)) begin
        miscompares++; $display("FAIL ovf_pulse[%0d]: got %b, expected %b", i, overflow, i == 4);
      end
    end
    @(negedge clk);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_width: got %b, expected 0", overflow); end
    tick_en = 1'b1;
    score_frames(4, 1'b1, "ovf");
    repeat (300) @(negedge clk);
    vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL ovf_extra_frames: got %0d, expected 0", got_q.size()); end
  endtask

  task automatic test_coincident();
    wait_idle();
    tick_en = 1'b0;
    @(posedge clk); #1 wr_en = 1'b1; data_in = 8'h5A; man_tick = 1'b1;
    @(posedge clk); #1 wr_en = 1'b0; man_tick = 1'b0;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL coin_no_start: got %b, expected 1", tx); end
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL coin_count: got %0d, expected 1", fifo_count); end
    @(posedge clk); #1 man_tick = 1'b1;
    @(posedge clk); #1 man_tick = 1'b0;
    @(negedge clk);
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL coin_start: got %b, expected 0", tx); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL coin_busy: got %b, expected 1", busy); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL coin_pop: got %0d, expected 0", fifo_count); end
    expect_word(8'h5A);
    tick_en = 1'b1;
    score_frames(1, 1'b0, "coin");
  endtask

  task automatic test_continuous_tick();
    wait_idle();
    tick_en = 1'b0;
    @(posedge clk); #1 tick_period = 1; wr_en = 1'b1; data_in = 8'hC3; expect_word(8'hC3);
    @(posedge clk); #1 data_in = 8'h3C; expect_word(8'h3C);
    @(posedge clk); #1 wr_en = 1'b0; tick_en = 1'b1;
    score_frames(2, 1'b1, "cont");
    wait_idle();
    tick_en = 1'b0;
    @(posedge clk); #1 tick_period = 16;
  endtask

  task automatic test_reset_mid_frame();
    int guard = 0;
    tick_en = 1'b1;
    @(posedge clk); #1 wr_en = 1'b1; data_in = 8'h12;
    @(posedge clk); #1 data_in = 8'h34;
    @(posedge clk); #1 data_in = 8'h56;
    @(posedge clk); #1 wr_en = 1'b0;
    while (busy !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy !== 1'b1) timeouts++;
    repeat (3) wait_tick();
    vectors++; if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL rstmid_queued: got %0d, expected 2", fifo_count); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx: got %b, expected 1", tx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL rstmid_count: got %0d, expected 0", fifo_count); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rstmid_full: got %b, expected 0", full); end
    repeat (400) @(negedge clk);
    vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL rstmid_frames: got %0d, expected 0", got_q.size()); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_later_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_integrity();
    vectors++; if (glitches !== 0) begin miscompares++; $display("FAIL bit_hold: got %0d off-tick tx changes, expected 0", glitches); end
    vectors++; if (timeouts !== 0) begin miscompares++; $display("FAIL wait_bound: got %0d expired waits, expected 0", timeouts); end
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL leftover: got %0d unsent words, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_8e1();
    test_parity();
    test_7n2();
    test_back_to_back();
    test_overflow();
    test_coincident();
    test_continuous_tick();
    test_reset_mid_frame();
    test_integrity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
